// File: rtl/baby_store_pkg.sv
// Shared types and constants for the Manchester Baby store/loader.
// Imported by the controller and its RAM.
package baby_store_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        HALT = 3'd3,
        DUMP = 3'd4
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/baby_store_mem.sv
// Single-port store for the Baby: synchronous write, registered read.
// The controller owns the port and muxes core, load and dump traffic.
module baby_store_mem
    import baby_store_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] store [2**ADDR_W];

    // array write; storage is deliberately left unreset
    always_ff @(posedge clock) begin
        if (en && we) begin
            store[addr] <= wdata;
        end
    end

    // read register updates only on an enabled read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= store[addr];
        end
    end

endmodule

// File: rtl/baby_store_ctrl.sv
// Store-and-loader controller for the Manchester Baby core.
// Loads programs, serves core strobes, dumps RAM after stop.
module baby_store_ctrl
    import baby_store_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int CNT_W     = 16,
    parameter bit AUTO_DUMP = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n_i,
    input  logic              mem_strobe_i,
    input  logic [ADDR_W-1:0] ram_addr_i,
    input  logic              ram_rw_en_i,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_data_oe_o,
    input  logic              stop_lamp_i,
    output logic              core_reset_o,
    input  logic              cmd_load_i,
    input  logic              cmd_run_i,
    input  logic              cmd_dump_i,
    input  logic              cmd_abort_i,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_last_o,
    output logic [2:0]        state_o,
    output logic [CNT_W-1:0]  run_count_o
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic              addr_clr;
    logic              addr_inc;
    logic              cnt_clr;
    logic [CNT_W-1:0]  run_count;
    logic              dump_vld;

    logic              load_hs;
    logic              dump_hs;
    logic              dump_fetch;
    logic              dump_at_last;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              run_view;
    logic [DATA_W-1:0] ram_hold;

    assign load_hs      = (state == LOAD) && load_valid_i;
    assign dump_hs      = (state == DUMP) && dump_vld && dump_ready_i;
    assign dump_fetch   = (state == DUMP) && !dump_vld;
    assign dump_at_last = (addr_cnt == ADDR_MAX);

    // next state and counter control, abort > load > dump > run
    always_comb begin
        state_nxt = state;
        addr_clr  = 1'b0;
        addr_inc  = 1'b0;
        cnt_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                priority case (1'b1)
                    cmd_abort_i: state_nxt = IDLE;
                    cmd_load_i: begin
                        state_nxt = LOAD;
                        addr_clr  = 1'b1;
                    end
                    cmd_dump_i: begin
                        state_nxt = DUMP;
                        addr_clr  = 1'b1;
                    end
                    cmd_run_i: begin
                        state_nxt = RUN;
                        cnt_clr   = 1'b1;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
            LOAD: begin
                if (cmd_abort_i) begin
                    state_nxt = IDLE;
                end else if (load_hs) begin
                    addr_inc = 1'b1;
                    if (dump_at_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            RUN: begin
                if (cmd_abort_i) begin
                    state_nxt = IDLE;
                end else if (stop_lamp_i) begin
                    if (AUTO_DUMP) begin
                        state_nxt = DUMP;
                        addr_clr  = 1'b1;
                    end else begin
                        state_nxt = HALT;
                    end
                end
            end
            HALT: begin
                priority case (1'b1)
                    cmd_abort_i: state_nxt = IDLE;
                    cmd_load_i: begin
                        state_nxt = LOAD;
                        addr_clr  = 1'b1;
                    end
                    cmd_dump_i: begin
                        state_nxt = DUMP;
                        addr_clr  = 1'b1;
                    end
                    default: state_nxt = HALT;
                endcase
            end
            DUMP: begin
                if (cmd_abort_i) begin
                    state_nxt = IDLE;
                end else if (dump_hs) begin
                    if (dump_at_last) begin
                        state_nxt = IDLE;
                    end else begin
                        addr_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // shared load/dump address counter; state exit prevents wrap
    always_ff @(posedge clock or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_cnt <= '0;
        end else if (addr_clr) begin
            addr_cnt <= '0;
        end else if (addr_inc) begin
            addr_cnt <= addr_cnt + 1'b1;
        end
    end

    // saturating count of strobes served in RUN
    always_ff @(posedge clock or negedge reset_n_i) begin
        if (!reset_n_i) begin
            run_count <= '0;
        end else if (cnt_clr) begin
            run_count <= '0;
        end else if (state == RUN && mem_strobe_i
                     && run_count != CNT_MAX) begin
            run_count <= run_count + 1'b1;
        end
    end

    // dump valid: fetch cycle, then hold until accepted
    always_ff @(posedge clock or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dump_vld <= 1'b0;
        end else if (state == DUMP && state_nxt == DUMP) begin
            dump_vld <= dump_vld ? !dump_ready_i : 1'b1;
        end else begin
            dump_vld <= 1'b0;
        end
    end

    // RAM port mux: core in RUN, stream in LOAD, fetch in DUMP
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = RW_READ;
        mem_addr  = addr_cnt;
        mem_wdata = load_data_i;
        unique case (state)
            RUN: begin
                mem_en    = mem_strobe_i;
                mem_we    = (ram_rw_en_i == RW_WRITE);
                mem_addr  = ram_addr_i;
                mem_wdata = ram_data_i;
            end
            LOAD: begin
                mem_en = load_valid_i;
                mem_we = RW_WRITE;
            end
            DUMP: begin
                mem_en = dump_fetch;
                mem_we = RW_READ;
            end
            default: mem_en = 1'b0;
        endcase
    end

    baby_store_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock   (clock),
        .reset_n (reset_n_i),
        .en      (mem_en),
        .we      (mem_we),
        .addr    (mem_addr),
        .wdata   (mem_wdata),
        .rdata   (mem_rdata)
    );

    // park the last core read when a dump fetch reuses the read register
    always_ff @(posedge clock or negedge reset_n_i) begin
        if (!reset_n_i) begin
            run_view <= 1'b1;
            ram_hold <= '0;
        end else if (mem_en && !mem_we) begin
            if (state == RUN) begin
                run_view <= 1'b1;
            end else begin
                if (run_view) begin
                    ram_hold <= mem_rdata;
                end
                run_view <= 1'b0;
            end
        end
    end

    assign ram_data_o    = run_view ? mem_rdata : ram_hold;
    assign ram_data_oe_o = (state == RUN) && (ram_rw_en_i == RW_READ);
    assign core_reset_o  = !(state == RUN || state == HALT);
    assign load_ready_o  = (state == LOAD);
    assign dump_valid_o  = dump_vld;
    assign dump_data_o   = dump_vld ? mem_rdata : '0;
    assign dump_last_o   = dump_vld && dump_at_last;
    assign state_o       = state;
    assign run_count_o   = run_count;

endmodule

// File: tb/tb_baby_store_ctrl.sv
// Scoreboard bench for baby_store_ctrl.
// Random load/run/dump traffic against a plain array model.
`timescale 1ns/1ps
module tb_baby_store_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n_i;
    logic          mem_strobe_i;
    logic [AW-1:0] ram_addr_i;
    logic          ram_rw_en_i;
    logic [DW-1:0] ram_data_i;
    logic [DW-1:0] ram_data_o;
    logic          ram_data_oe_o;
    logic          stop_lamp_i;
    logic          core_reset_o;
    logic          cmd_load_i;
    logic          cmd_run_i;
    logic          cmd_dump_i;
    logic          cmd_abort_i;
    logic          load_valid_i;
    logic          load_ready_o;
    logic [DW-1:0] load_data_i;
    logic          dump_valid_o;
    logic          dump_ready_i;
    logic [DW-1:0] dump_data_o;
    logic          dump_last_o;
    logic [2:0]    state_o;
    logic [15:0]   run_count_o;

    logic          s_strobe;
    logic [AW-1:0] s_addr;
    logic          s_rw;
    logic          s_stop;
    logic          s_cmd_run;
    logic          s_cmd_abort;
    logic [DW-1:0] s_ram_data;
    logic          s_oe;
    logic          s_core_reset;
    logic          s_load_ready;
    logic          s_dump_valid;
    logic [DW-1:0] s_dump_data;
    logic          s_dump_last;
    logic [2:0]    s_state;
    logic [3:0]    s_run_count;

    baby_store_ctrl dut (
        .clock         (clock),
        .reset_n_i     (reset_n_i),
        .mem_strobe_i  (mem_strobe_i),
        .ram_addr_i    (ram_addr_i),
        .ram_rw_en_i   (ram_rw_en_i),
        .ram_data_i    (ram_data_i),
        .ram_data_o    (ram_data_o),
        .ram_data_oe_o (ram_data_oe_o),
        .stop_lamp_i   (stop_lamp_i),
        .core_reset_o  (core_reset_o),
        .cmd_load_i    (cmd_load_i),
        .cmd_run_i     (cmd_run_i),
        .cmd_dump_i    (cmd_dump_i),
        .cmd_abort_i   (cmd_abort_i),
        .load_valid_i  (load_valid_i),
        .load_ready_o  (load_ready_o),
        .load_data_i   (load_data_i),
        .dump_valid_o  (dump_valid_o),
        .dump_ready_i  (dump_ready_i),
        .dump_data_o   (dump_data_o),
        .dump_last_o   (dump_last_o),
        .state_o       (state_o),
        .run_count_o   (run_count_o)
    );

    baby_store_ctrl #(
        .CNT_W     (4),
        .AUTO_DUMP (1'b1)
    ) dut_s (
        .clock         (clock),
        .reset_n_i     (reset_n_i),
        .mem_strobe_i  (s_strobe),
        .ram_addr_i    (s_addr),
        .ram_rw_en_i   (s_rw),
        .ram_data_i    (32'h5a5a_0000),
        .ram_data_o    (s_ram_data),
        .ram_data_oe_o (s_oe),
        .stop_lamp_i   (s_stop),
        .core_reset_o  (s_core_reset),
        .cmd_load_i    (1'b0),
        .cmd_run_i     (s_cmd_run),
        .cmd_dump_i    (1'b0),
        .cmd_abort_i   (s_cmd_abort),
        .load_valid_i  (1'b0),
        .load_ready_o  (s_load_ready),
        .load_data_i   (32'h0),
        .dump_valid_o  (s_dump_valid),
        .dump_ready_i  (1'b0),
        .dump_data_o   (s_dump_data),
        .dump_last_o   (s_dump_last),
        .state_o       (s_state),
        .run_count_o   (s_run_count)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } dword_t;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] rd_q [$];
    dword_t        dump_q [$];
    int            exp_count;
    bit            exp_run;
    logic [DW-1:0] last_rd;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // monitor: read-data and dump-stream scoreboard
    bit            pend_rd;
    bit            prev_vld;
    bit            prev_rdy;
    bit            prev_hs;
    bit            prev_abort;
    logic [DW-1:0] prev_data;

    always @(negedge clock) begin
        if (!reset_n_i) begin
            pend_rd  = 0;
            prev_vld = 0;
            prev_hs  = 0;
        end else begin
            if (pend_rd) begin
                if (rd_q.size() == 0) begin
                    check("rd_spurious", 1, 0);
                end else begin
                    check("ram_data_o", ram_data_o, rd_q.pop_front());
                end
                pend_rd = 0;
            end
            if (exp_run && mem_strobe_i && !ram_rw_en_i) begin
                pend_rd = 1;
            end
            if (prev_hs) begin
                check("dump_gap", dump_valid_o, 0);
            end
            if (prev_vld && !prev_rdy && !prev_abort) begin
                check("dump_hold_valid", dump_valid_o, 1);
                check("dump_hold_data", dump_data_o, prev_data);
            end
            prev_hs = 0;
            if (dump_valid_o && dump_ready_i) begin
                if (dump_q.size() == 0) begin
                    check("dump_spurious", 1, 0);
                end else begin
                    dword_t e;
                    e = dump_q.pop_front();
                    check("dump_data", dump_data_o, e.data);
                    check("dump_last", dump_last_o, e.last);
                end
                prev_hs = 1;
            end
            prev_vld   = dump_valid_o;
            prev_rdy   = dump_ready_i;
            prev_data  = dump_data_o;
            prev_abort = cmd_abort_i;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [AW-1:0] a, input bit rw,
                          input logic [DW-1:0] d);
        mem_strobe_i = 1'b1;
        ram_addr_i   = a;
        ram_rw_en_i  = rw;
        ram_data_i   = d;
        if (exp_run) begin
            if (rw) begin
                model[a] = d;
            end else begin
                rd_q.push_back(model[a]);
                last_rd = model[a];
            end
            if (exp_count < 65535) exp_count++;
        end
        #1;
        check("oe", ram_data_oe_o, exp_run && !rw);
        tick();
        mem_strobe_i = 1'b0;
        ram_rw_en_i  = 1'b0;
    endtask

    task automatic start_dump();
        cmd_dump_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            dump_q.push_back('{data: model[i], last: (i == DEPTH - 1)});
        end
        tick();
        cmd_dump_i = 1'b0;
    endtask

    task automatic drain_dump();
        int n;
        n = 0;
        while (dump_q.size() > 0 && n < 400) begin
            dump_ready_i = ($urandom_range(0, 99) < 60);
            tick();
            n++;
        end
        dump_ready_i = 1'b0;
        if (dump_q.size() > 0) begin
            check("dump_timeout", dump_q.size(), 0);
            dump_q.delete();
        end
        check("dump_end_state", state_o, 0);
    endtask

    initial begin
        reset_n_i    = 1'b0;
        mem_strobe_i = 1'b0;
        ram_addr_i   = '0;
        ram_rw_en_i  = 1'b0;
        ram_data_i   = '0;
        stop_lamp_i  = 1'b0;
        cmd_load_i   = 1'b0;
        cmd_run_i    = 1'b0;
        cmd_dump_i   = 1'b0;
        cmd_abort_i  = 1'b0;
        load_valid_i = 1'b0;
        load_data_i  = '0;
        dump_ready_i = 1'b0;
        s_strobe     = 1'b0;
        s_addr       = '0;
        s_rw         = 1'b0;
        s_stop       = 1'b0;
        s_cmd_run    = 1'b0;
        s_cmd_abort  = 1'b0;
        exp_run      = 0;
        exp_count    = 0;
        last_rd      = '0;

        // reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_state", state_o, 0);
        check("rst_core_reset", core_reset_o, 1);
        check("rst_load_ready", load_ready_o, 0);
        check("rst_dump_valid", dump_valid_o, 0);
        check("rst_dump_data", dump_data_o, 0);
        check("rst_dump_last", dump_last_o, 0);
        check("rst_ram_data", ram_data_o, 0);
        check("rst_oe", ram_data_oe_o, 0);
        check("rst_run_count", run_count_o, 0);
        reset_n_i = 1'b1;
        tick();

        // load 32 words with valid held high
        cmd_load_i = 1'b1;
        tick();
        cmd_load_i   = 1'b0;
        load_valid_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] w;
            w = (i == 0) ? 32'h0000_0013 :
                (i == 1) ? 32'h0000_401f : $urandom;
            load_data_i = w;
            model[i]    = w;
            check("load_ready_hi", load_ready_o, 1);
            check("load_core_reset", core_reset_o, 1);
            tick();
        end
        load_valid_i = 1'b0;
        check("load_ready_drop", load_ready_o, 0);
        check("load_done_state", state_o, 0);
        check("load_done_core_reset", core_reset_o, 1);

        // run: directed read/write, then random strobes
        cmd_run_i = 1'b1;
        tick();
        cmd_run_i = 1'b0;
        exp_run   = 1;
        exp_count = 0;
        check("run_state", state_o, 2);
        check("run_core_reset", core_reset_o, 0);
        check("run_count_clr", run_count_o, 0);
        strobe(5'h01, 1'b0, '0);
        strobe(5'h1c, 1'b1, 32'hDEAD_BEEF);
        strobe(5'h1c, 1'b0, '0);
        tick();
        check("run_count_3", run_count_o, exp_count);
        for (int i = 0; i < 24; i++) begin
            logic [AW-1:0] a;
            bit            rw;
            a  = AW'($urandom_range(0, DEPTH - 1));
            rw = $urandom_range(0, 1) == 1;
            if (a == 5'h1c || a == 5'h05) rw = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            strobe(a, rw, $urandom);
        end
        repeat (3) tick();
        check("ram_data_hold", ram_data_o, last_rd);
        check("run_count_rand", run_count_o, exp_count);

        // write coincident with stop lamp still lands
        mem_strobe_i = 1'b1;
        ram_addr_i   = 5'h05;
        ram_rw_en_i  = 1'b1;
        ram_data_i   = $urandom;
        model[5]     = ram_data_i;
        exp_count++;
        stop_lamp_i  = 1'b1;
        tick();
        exp_run      = 0;
        stop_lamp_i  = 1'b0;
        mem_strobe_i = 1'b0;
        ram_rw_en_i  = 1'b0;
        check("halt_state", state_o, 3);
        check("halt_core_reset", core_reset_o, 0);
        check("halt_count", run_count_o, exp_count);

        // strobes and cmd_run are ignored in HALT
        strobe(5'h06, 1'b1, 32'hBAD0_BAD0);
        strobe(5'h06, 1'b0, '0);
        tick();
        check("halt_ram_data", ram_data_o, last_rd);
        check("halt_count_hold", run_count_o, exp_count);
        cmd_run_i = 1'b1;
        tick();
        cmd_run_i = 1'b0;
        check("halt_run_ignored", state_o, 3);

        // full dump with random backpressure
        start_dump();
        check("dump_state", state_o, 4);
        check("dump_core_reset", core_reset_o, 1);
        drain_dump();
        check("ram_data_after_dump", ram_data_o, last_rd);

        // backpressure hold, then abort mid-dump
        start_dump();
        begin
            int n;
            n = 0;
            while (!dump_valid_o && n < 10) begin
                tick();
                n++;
            end
            check("dump_valid_rise", dump_valid_o, 1);
        end
        repeat (10) tick();
        check("bp_valid", dump_valid_o, 1);
        check("bp_data", dump_data_o, model[0]);
        dump_ready_i = 1'b1;
        begin
            int n;
            n = 0;
            while (dump_q.size() > 29 && n < 20) begin
                tick();
                n++;
            end
            check("bp_three_words", dump_q.size(), 29);
        end
        dump_ready_i = 1'b0;
        repeat (2) tick();
        cmd_abort_i = 1'b1;
        tick();
        cmd_abort_i = 1'b0;
        check("abort_valid", dump_valid_o, 0);
        check("abort_state", state_o, 0);
        dump_q.delete();
        tick();

        // load and abort together in IDLE
        cmd_load_i  = 1'b1;
        cmd_abort_i = 1'b1;
        tick();
        cmd_load_i  = 1'b0;
        cmd_abort_i = 1'b0;
        check("ld_abort_state", state_o, 0);
        check("ld_abort_ready", load_ready_o, 0);

        // saturation and auto-dump on the narrow instance
        begin
            int s_exp;
            s_exp     = 0;
            s_cmd_run = 1'b1;
            tick();
            s_cmd_run = 1'b0;
            for (int i = 0; i < 20; i++) begin
                s_strobe = 1'b1;
                s_addr   = AW'($urandom_range(0, DEPTH - 1));
                s_rw     = 1'b0;
                s_exp    = (s_exp < 15) ? s_exp + 1 : 15;
                tick();
                s_strobe = 1'b0;
                if (i == 9) check("sat_count_10", s_run_count, s_exp);
            end
            check("sat_count_15", s_run_count, 15);
            s_stop = 1'b1;
            tick();
            s_stop = 1'b0;
            check("auto_dump_state", s_state, 4);
            check("auto_dump_core_reset", s_core_reset, 1);
            s_cmd_abort = 1'b1;
            tick();
            s_cmd_abort = 1'b0;
            check("auto_dump_abort", s_state, 0);
            check("auto_dump_ready", s_load_ready, 0);
        end

        // async reset mid-LOAD, then prove RAM survived
        cmd_load_i = 1'b1;
        tick();
        cmd_load_i   = 1'b0;
        load_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load_data_i = $urandom;
            model[i]    = load_data_i;
            tick();
        end
        check("mid_load_state", state_o, 1);
        #2;
        reset_n_i    = 1'b0;
        load_valid_i = 1'b0;
        #1;
        check("areset_state", state_o, 0);
        check("areset_ready", load_ready_o, 0);
        check("areset_core_reset", core_reset_o, 1);
        check("areset_count", run_count_o, 0);
        @(posedge clock);
        #2;
        reset_n_i = 1'b1;
        tick();
        start_dump();
        drain_dump();

        repeat (3) tick();
        check("rd_q_empty", rd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/baby_store_ctrl.md
Name: baby_store_ctrl

Overview:
Parametrised, synthesizable store-and-loader for the Manchester Baby core. It replaces the behavioural testbench memory with on-chip RAM. The RAM has a strobe-qualified core port and a valid/ready load stream for programs. It can dump RAM contents after the stop lamp lights. It holds the core in reset while loading or dumping and sits between the core's RAM pins and the chip-level program/debug interface.

Parameters:
DATA_W, 32, store word width
ADDR_W, 5, address width; depth = 2**ADDR_W
CNT_W, 16, width of saturating run-strobe counter
AUTO_DUMP, 0, 1 = enter DUMP directly on stop lamp instead of HALT

Ports:
clock  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
mem_strobe_i  in  1  one-cycle RAM access enable from core clock tree, synchronous to clock
ram_addr_i  in  ADDR_W  core address
ram_rw_en_i  in  1  0 = read, 1 = write
ram_data_i  in  DATA_W  core write data
ram_data_o  out  DATA_W  registered read data
ram_data_oe_o  out  1  high when ram_data_o should drive the core's bidirectional data bus (RUN and ram_rw_en_i = 0)
stop_lamp_i  in  1  core stop lamp, level
core_reset_o  out  1  active-high reset to core
cmd_load_i / cmd_run_i / cmd_dump_i / cmd_abort_i  in  1 each  command pulses
load_valid_i  in  1  load word valid
load_ready_o  out  1  load word accepted when valid and ready
load_data_i  in  DATA_W  load word
dump_valid_o  out  1  dump word valid
dump_ready_i  in  1  dump sink ready
dump_data_o  out  DATA_W  dump word
dump_last_o  out  1  marks word at address 2**ADDR_W-1
state_o  out  3  current state encoding
run_count_o  out  CNT_W  strobes served in RUN, saturating

Behaviour:
- Reset (async assert, sync deassert in consumer) -> state IDLE. All outputs 0 except core_reset_o = 1. RAM contents are undefined.
- States: IDLE, LOAD, RUN, HALT, DUMP.
- Command priority on the same cycle: abort > load > dump > run. Commands not listed for the current state are ignored.
- IDLE:
  - cmd_load -> LOAD with addr counter 0.
  - cmd_dump -> DUMP with addr 0.
  - cmd_run -> RUN; run_count_o cleared.
- LOAD:
  - load_ready_o = 1.
  - Each handshake writes RAM[cnt] and increments cnt.
  - Handshake at cnt = 2**ADDR_W-1 -> IDLE next cycle, and load_ready_o drops that next cycle.
  - abort -> IDLE. Partial contents are kept.
- RUN:
  - core_reset_o = 0.
  - On mem_strobe_i with rw = 0: ram_data_o <= RAM[ram_addr_i], visible on the next cycle (1-cycle latency). ram_data_o holds between strobes.
  - On mem_strobe_i with rw = 1: RAM[ram_addr_i] <= ram_data_i.
  - Each strobe increments run_count_o, saturating at all-ones.
  - stop_lamp_i = 1, sampled each cycle -> HALT, or DUMP with addr 0 if AUTO_DUMP.
  - A strobe in the same cycle as the stop lamp is still served.
  - abort -> IDLE.
- HALT:
  - core_reset_o = 0, so the core's stopped state stays observable.
  - Strobes are ignored.
  - cmd_dump -> DUMP; cmd_load -> LOAD; abort -> IDLE; cmd_run is ignored.
- DUMP:
  - core_reset_o = 1.
  - RAM is read synchronously. dump_valid_o rises one cycle after the address is issued and is held with stable data until dump_ready_i.
  - After each handshake, valid is low for exactly one cycle while the next word is fetched. Minimum 2 cycles per word.
  - dump_last_o = 1 with the final word. Its handshake -> IDLE.
  - abort -> IDLE immediately; valid drops.
- core_reset_o = 1 in IDLE, LOAD and DUMP.
- Strobes outside RUN never modify RAM or ram_data_o.
- Address counters are ADDR_W wide, with no separate overflow bit; wrap is prevented by the state exit.
- Reset mid-LOAD or mid-DUMP returns to IDLE. RAM is not cleared.

Decomposition:
- baby_store_pkg holds:
  - state_t enum (IDLE = 0, LOAD = 1, RUN = 2, HALT = 3, DUMP = 4)
  - default DATA_W and ADDR_W localparams
  - the RW_READ / RW_WRITE constants
- One sub-module, baby_store_mem: a single-port, sync-read, sync-write register array. It is parametrised by DATA_W and ADDR_W and has a muxed port owned by the controller FSM.

Test Plan:
1. Reset, then load: cmd_load, stream 32 words 0x00000013, 0x0000401f, ... with valid held high -> load_ready_o high for 32 cycles, state_o returns to IDLE (0), core_reset_o stays 1.
2. Run read/write: cmd_run, strobe read at addr 0x01 -> ram_data_o = 0x0000401f one cycle later with ram_data_oe_o = 1. Strobe write 0xDEADBEEF to 0x1c, then strobe read 0x1c -> 0xDEADBEEF. run_count_o = 3.
3. Stop and dump with AUTO_DUMP = 0: assert stop_lamp_i -> HALT (3). cmd_dump with dump_ready_i random -> 32 words out in address order, including 0xDEADBEEF at index 28 and dump_last_o on word 31, then IDLE.
4. Backpressure and abort: dump_ready_i low for 10 cycles -> dump_data_o and valid stable throughout. cmd_abort mid-dump -> valid low next cycle, state IDLE.
5. Simultaneous events: cmd_load and cmd_abort in the same cycle in IDLE -> stays IDLE. Strobe write coincident with stop lamp -> write lands (verified by a later dump).
6. Saturation and async reset: CNT_W = 4, 20 strobes -> run_count_o = 15. reset_n_i low mid-LOAD -> outputs reset immediately with no clock edge, state IDLE.
